mouse_quadrature: RTL and testbench

- Converts MiSTer PS/2 mouse packets (hps_io ps2_mouse bus) into Atari ST-mouse style quadrature signals on the joystick port lines.
- Outputs feed the JOY1/JOY2 digital inputs of atari800top through the swap mux; trackball-aware software sees a real mouse.
- Signed per-axis accumulators absorb packet deltas. A fixed-rate step timer drains each accumulator by one count per tick, advancing a 2-bit Gray phase per axis.

---
 rtl/mouse_quadrature.sv | 156 +++++++++++++++
 tb/tb_mouse_quadrature.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_quadrature.sv
// PS/2 mouse packets to Atari ST quadrature joystick lines with rate-limited stepping.
// Build option MOUSE_QUADRATURE_CX22_EN adds cx22_mode for CX22 trakball clock/direction output.
module mouse_quadrature #(
  parameter int STEP_DIV = 4096,
  parameter int ACC_MAX  = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
`ifdef MOUSE_QUADRATURE_CX22_EN
  input  logic        cx22_mode,
`endif
  input  logic [24:0] ps2_mouse,
  output logic [8:0]  joy_out,
  output logic        moving
);

  localparam int                 CNT_W    = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(STEP_DIV - 1);
  localparam logic signed [10:0] SAT_HI   = 11'(ACC_MAX);
  localparam logic signed [10:0] SAT_LO   = -SAT_HI;

  logic             old_stb_reg;
  logic             primed_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [8:0]       joy_reg;
  logic             moving_reg;

  logic             tick;
  logic             ev;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] delta_w [2];
  logic [1:0]       phase_w [2];
  logic             nz_w [2];
`ifdef MOUSE_QUADRATURE_CX22_EN
  logic             clk_w [2];
  logic             dir_w [2];
`endif
  logic [3:0]       quad;
  logic             unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  assign tick = (cnt_reg == '0);
  assign ev   = primed_reg & (old_stb_reg != ps2_mouse[24]);

  // Y is negated: PS/2 reports up as positive, the ST expects down as positive.
  assign dx = {{2{ps2_mouse[4]}}, ps2_mouse[4], ps2_mouse[15:8]};
  assign dy = -$signed({{2{ps2_mouse[5]}}, ps2_mouse[5], ps2_mouse[23:16]});

  assign delta_w[0] = ev ? dx : 11'sd0;
  assign delta_w[1] = ev ? dy : 11'sd0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_stb_reg <= 1'b0;
      primed_reg  <= 1'b0;
      cnt_reg     <= CNT_LOAD;
    end else begin
      old_stb_reg <= ps2_mouse[24];
      primed_reg  <= 1'b1;
      cnt_reg     <= tick ? CNT_LOAD : cnt_reg - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [9:0]  acc_reg;
      logic signed [9:0]  acc_next;
      logic signed [10:0] sum;
      logic signed [10:0] step_val;
      logic [1:0]         phase_reg;
      logic               step_up;
      logic               step_dn;

      // Direction comes from the current accumulator, before the new delta lands.
      assign step_up  = tick & enable & (acc_reg > 10'sd0);
      assign step_dn  = tick & enable & (acc_reg < 10'sd0);
      assign step_val = step_up ? -11'sd1 : (step_dn ? 11'sd1 : 11'sd0);

      always_comb begin
        sum      = $signed({acc_reg[9], acc_reg}) + delta_w[gi] + step_val;
        acc_next = sum[9:0];
        if (!enable)
          acc_next = '0;
        else if (sum > SAT_HI)
          acc_next = SAT_HI[9:0];
        else if (sum < SAT_LO)
          acc_next = SAT_LO[9:0];
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          acc_reg   <= '0;
          phase_reg <= '0;
        end else begin
          acc_reg <= acc_next;
          if (step_up)
            phase_reg <= phase_reg + 2'd1;
          else if (step_dn)
            phase_reg <= phase_reg - 2'd1;
        end
      end

      assign phase_w[gi] = phase_reg;
      assign nz_w[gi]    = (acc_reg != 10'sd0);

`ifdef MOUSE_QUADRATURE_CX22_EN
      // CX22: clock toggles per step, direction is 1 for a negative step (left / up).
      logic clk_reg;
      logic dir_reg;

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          clk_reg <= 1'b0;
          dir_reg <= 1'b0;
        end else if (step_up | step_dn) begin
          clk_reg <= ~clk_reg;
          dir_reg <= step_dn;
        end
      end

      assign clk_w[gi] = clk_reg;
      assign dir_w[gi] = dir_reg;
`endif
    end
  endgenerate

  // Gray phase {A,B}: A = phase[1], B = phase[1] ^ phase[0]; packed as {XB, XA, YA, YB}.
  always_comb begin
    quad = {phase_w[0][1] ^ phase_w[0][0], phase_w[0][1],
            phase_w[1][1], phase_w[1][1] ^ phase_w[1][0]};
`ifdef MOUSE_QUADRATURE_CX22_EN
    if (cx22_mode)
      quad = {clk_w[0], dir_w[0], clk_w[1], dir_w[1]};
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_reg    <= '0;
      moving_reg <= 1'b0;
    end else begin
      joy_reg[8:6] <= 3'b000;
      joy_reg[5:4] <= enable ? ps2_mouse[1:0] : 2'b00;
      joy_reg[3:0] <= quad;
      moving_reg   <= nz_w[0] | nz_w[1];
    end
  end

  assign joy_out = joy_reg;
  assign moving  = moving_reg;

endmodule

// File: tb/tb_mouse_quadrature.sv
// Scoreboard bench for mouse_quadrature: expected joystick phase codes are queued per packet
// and popped whenever the quadrature lines change.
module tb_mouse_quadrature;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable  = 1'b1;
  logic [24:0] ps2_mouse = '0;
  logic [8:0]  joy_out;
  logic        moving;

  mouse_quadrature #(.STEP_DIV(4), .ACC_MAX(255)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
`ifdef MOUSE_QUADRATURE_CX22_EN
    .cx22_mode (1'b0),
`endif
    .ps2_mouse (ps2_mouse),
    .joy_out   (joy_out),
    .moving    (moving)
  );

  always #5 clk_sys = ~clk_sys;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q [$];
  logic [3:0] last_joy = 4'b0000;
  int         steps_seen = 0;
  logic [1:0] px = 2'd0;
  logic [1:0] py = 2'd0;
  int         tick_cnt = 3;
  logic       stb = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] gray(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // {XB, XA, YA, YB}
  function automatic logic [3:0] enc(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] gx, gy;
    gx = gray(x);
    gy = gray(y);
    return {gx[0], gx[1], gy[1], gy[0]};
  endfunction

  // Step-timer position, used only to place packets relative to ticks.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tick_cnt <= 3;
    else          tick_cnt <= (tick_cnt == 0) ? 3 : tick_cnt - 1;
  end

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      last_joy = joy_out[3:0];
    end else if (joy_out[3:0] !== last_joy) begin
      logic [3:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : last_joy;
      chk("joy_step", {28'd0, joy_out[3:0]}, {28'd0, e});
      last_joy = joy_out[3:0];
      steps_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic send(input int dx, input int dy_raw);
    logic [8:0] x9, y9;
    x9 = 9'(dx);
    y9 = 9'(dy_raw);
    stb = ~stb;
    ps2_mouse[24]    = stb;
    ps2_mouse[4]     = x9[8];
    ps2_mouse[15:8]  = x9[7:0];
    ps2_mouse[5]     = y9[8];
    ps2_mouse[23:16] = y9[7:0];
    $display("pkt dx=%0d dy_raw=%0d enable=%0b t=%0t", dx, dy_raw, enable, $time);
  endtask

  task automatic push_x(input int n);
    for (int i = 0; i < ((n < 0) ? -n : n); i++) begin
      px = (n > 0) ? px + 2'd1 : px - 2'd1;
      exp_q.push_back(enc(px, py));
    end
  endtask

  task automatic push_y(input int n);
    for (int i = 0; i < ((n < 0) ? -n : n); i++) begin
      py = (n > 0) ? py + 2'd1 : py - 2'd1;
      exp_q.push_back(enc(px, py));
    end
  endtask

  task automatic wait_slot(input int k);
    for (int i = 0; i < 8; i++) begin
      if (tick_cnt == k) break;
      cyc(1);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic wait_steps(input string tag, input int base, input int n, input int budget);
    int c;
    c = 0;
    while ((steps_seen - base) < n && c < budget) begin
      cyc(1);
      c++;
    end
    chk(tag, steps_seen - base, n);
  endtask

  initial begin
    int base;
    ps2_mouse[24] = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_joy", {23'd0, joy_out}, 0);
    chk("rst_mov", {31'd0, moving}, 0);
    cyc(3);
    reset_n = 1'b1;

    // Strobe held high through reset release: no event may be taken.
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle", {22'd0, joy_out, moving}, 0);
    end

    send(3, 0);
    push_x(3);
    cyc(2);
    chk("mov_on", {31'd0, moving}, 1);
    wait_drain("drain_p3", 100);
    cyc(2);
    chk("mov_off", {31'd0, moving}, 0);

    send(1, 0);
    push_x(1);
    wait_drain("drain_p1", 50);
    send(-2, 0);
    push_x(-2);
    wait_drain("drain_m2", 50);
    chk("ph_m2", {28'd0, joy_out[3:0]}, 32'b1100);

    // Two back-to-back +200 packets clear of any tick: must clamp at 255 steps.
    wait_slot(3);
    send(200, 0);
    cyc(1);
    send(200, 0);
    push_x(255);
    cyc(3);
    chk("sat_mov", {31'd0, moving}, 1);
    wait_drain("drain_sat", 1100);
    cyc(8);
    chk("sat_end", {31'd0, moving}, 0);

    // Packet landing on a tick with acc=5: step and delta both apply.
    wait_slot(3);
    send(5, 0);
    push_x(6);
    wait_slot(0);
    base = steps_seen;
    send(1, 0);
    cyc(1);
    chk("coin_t0", steps_seen - base, 0);
    cyc(1);
    chk("coin_t1", steps_seen - base, 1);
    wait_drain("drain_coin", 60);

    send(0, 1);
    push_y(-1);
    wait_drain("drain_y", 30);
    chk("y_neg", {28'd0, joy_out[3:0]}, 32'b0110);

    ps2_mouse[1:0] = 2'b11;
    cyc(2);
    chk("btn", {30'd0, joy_out[5:4]}, 2'b11);
    ps2_mouse[1] = 1'b0;
    cyc(2);
    chk("btn_l", {30'd0, joy_out[5:4]}, 2'b01);

    // Disable mid-drain.
    base = steps_seen;
    send(10, 0);
    push_x(3);
    wait_steps("en_steps", base, 3, 40);
    enable = 1'b0;
    cyc(1);
    chk("en_btn", {31'd0, joy_out[4]}, 0);
    cyc(1);
    chk("en_mov", {31'd0, moving}, 0);
    cyc(2);
    send(5, 0);
    cyc(20);
    chk("en_hold", {28'd0, joy_out[3:0]}, 32'b1110);
    chk("en_ign", {31'd0, moving}, 0);
    enable = 1'b1;
    cyc(2);
    chk("reen_btn", {31'd0, joy_out[4]}, 1);
    send(1, 0);
    push_x(1);
    wait_drain("drain_reen", 30);
    chk("reen_ph", {28'd0, joy_out[3:0]}, 32'b0110);

    // Asynchronous reset mid-drain.
    base = steps_seen;
    send(20, 0);
    push_x(3);
    wait_steps("ar_steps", base, 3, 40);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_joy", {23'd0, joy_out}, 0);
    chk("arst_mov", {31'd0, moving}, 0);
    exp_q.delete();
    px = 2'd0;
    py = 2'd0;
    ps2_mouse[1:0] = 2'b00;
    cyc(3);
    reset_n = 1'b1;
    cyc(12);
    chk("post_idle", {22'd0, joy_out, moving}, 0);
    send(2, 0);
    push_x(2);
    wait_drain("drain_post", 30);
    chk("post_ph", {28'd0, joy_out[3:0]}, 32'b1100);

    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
